// File: rtl/servo_sched.sv
// servo_sched
//
// Four-channel hobby-servo PWM scheduler. A 20 ms frame is split into four
// equal time slots; channel k owns slot k and drives a single pulse at the
// very start of its slot whose width is the channel's active position.
//
// Each channel keeps two position registers. The shadow register is written
// through the wr/wr_ch/wr_pos port at any time. The active register drives
// pulse generation. Active registers are refreshed from shadow only at a
// frame boundary, so a pulse never changes width halfway through a frame.
//
// Ports:
//    clk        system clock, single clock domain
//    rst        synchronous, active-high reset
//    ena        level; 1 = keep generating frames, 0 = stop after current pulse
//    wr         single-cycle write strobe for a channel position
//    wr_ch      channel index for wr
//    wr_pos     requested pulse width in clk cycles (0 disables the channel)
//    servo      PWM outputs, one bit per channel
//    frame_tick one-cycle pulse during the first cycle of every frame
//    busy       high whenever the scheduler is not idle

module servo_sched #(
   parameter int T_SLOT  = 60000,
   parameter int POS_MIN = 6000,
   parameter int POS_MAX = 30000,
   parameter int N       = 18
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic         wr,
   input  logic [1:0]   wr_ch,
   input  logic [N-1:0] wr_pos,
   output logic [3:0]   servo,
   output logic         frame_tick,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [N-1:0] SLOT_LAST = N'(T_SLOT - 1);
   localparam logic [N-1:0] POS_LO    = N'(POS_MIN);
   localparam logic [N-1:0] POS_HI    = N'(POS_MAX);

   state_t       state;
   logic [1:0]   slot;
   logic [N-1:0] slot_cnt;
   logic [N-1:0] shadow [4];
   logic [N-1:0] active [4];

   // Keep written positions inside the range a servo can physically follow.
   // Zero is left alone because it means "channel disabled" rather than a
   // very short pulse.
   function automatic logic [N-1:0] clamp_pos(input logic [N-1:0] p);
      logic [N-1:0] r;
      if (p == '0) begin
         r = '0;
      end else if (p < POS_LO) begin
         r = POS_LO;
      end else if (p > POS_HI) begin
         r = POS_HI;
      end else begin
         r = p;
      end
      return r;
   endfunction

   // Main scheduler. Shadow writes happen in every state, and the active
   // registers copy the shadow registers with non-blocking reads, so a write
   // that lands on a reload edge is seen only at the next frame boundary.
   // RUN walks the slots back to back. Dropping ena moves to DRAIN, which
   // lets the current pulse finish before falling back to IDLE. Once in
   // DRAIN, ena is ignored until IDLE has been reached.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         slot       <= 2'd0;
         slot_cnt   <= '0;
         frame_tick <= 1'b0;
         for (int k = 0; k < 4; k++) begin
            shadow[k] <= '0;
            active[k] <= '0;
         end
      end else begin
         frame_tick <= 1'b0;

         if (wr) begin
            shadow[wr_ch] <= clamp_pos(wr_pos);
         end

         case (state)
            IDLE: begin
               slot     <= 2'd0;
               slot_cnt <= '0;
               if (ena) begin
                  state      <= RUN;
                  frame_tick <= 1'b1;
                  for (int k = 0; k < 4; k++) begin
                     active[k] <= shadow[k];
                  end
               end
            end

            RUN: begin
               if (!ena) begin
                  state <= DRAIN;
               end
               if (slot_cnt == SLOT_LAST) begin
                  slot_cnt <= '0;
                  slot     <= slot + 2'd1;
                  if (slot == 2'd3 && ena) begin
                     frame_tick <= 1'b1;
                     for (int k = 0; k < 4; k++) begin
                        active[k] <= shadow[k];
                     end
                  end
               end else begin
                  slot_cnt <= slot_cnt + 1'b1;
               end
            end

            DRAIN: begin
               if (slot_cnt >= active[slot]) begin
                  state    <= IDLE;
                  slot     <= 2'd0;
                  slot_cnt <= '0;
               end else if (slot_cnt == SLOT_LAST) begin
                  slot_cnt <= '0;
                  slot     <= slot + 2'd1;
               end else begin
                  slot_cnt <= slot_cnt + 1'b1;
               end
            end

            default: begin
               state    <= IDLE;
               slot     <= 2'd0;
               slot_cnt <= '0;
            end
         endcase
      end
   end

   // Pulse outputs are decoded straight from the counters. A channel is high
   // from the first cycle of its own slot until its count reaches the active
   // width, so a zero width never produces a pulse.
   always_comb begin
      servo = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         servo[k] = (state != IDLE) && (slot == 2'(k)) && (slot_cnt < active[k]);
      end
   end

   // Anything other than IDLE counts as busy, including the drain tail.
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_servo_sched.sv
// tb_servo_sched
//
// Self-checking bench for servo_sched with T_SLOT=100, POS_MIN=10,
// POS_MAX=50, so one frame is 400 cycles. A table of four-channel position
// sets is played through one frame each, followed by hand-written sequences
// for reload timing, draining, reset and frame-to-frame repetition.

module tb_servo_sched;

   localparam int T_SLOT  = 100;
   localparam int POS_MIN = 10;
   localparam int POS_MAX = 50;
   localparam int N       = 18;
   localparam int FRAME   = 4 * T_SLOT;

   logic         clk;
   logic         rst;
   logic         ena;
   logic         wr;
   logic [1:0]   wr_ch;
   logic [N-1:0] wr_pos;
   logic [3:0]   servo;
   logic         frame_tick;
   logic         busy;

   int assertions;
   int failures;

   int meas_width [4];
   int meas_off [4];
   int meas_ticks;
   int meas_first;

   typedef struct packed {
      logic [3:0][17:0] pos;
      logic [3:0][15:0] width;
   } vec_t;

   vec_t vecs [3];

   servo_sched #(
      .T_SLOT (T_SLOT),
      .POS_MIN(POS_MIN),
      .POS_MAX(POS_MAX),
      .N      (N)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .wr        (wr),
      .wr_ch     (wr_ch),
      .wr_pos    (wr_pos),
      .servo     (servo),
      .frame_tick(frame_tick),
      .busy      (busy)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      assertions++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] ch, input logic [N-1:0] pos);
      wr     = 1'b1;
      wr_ch  = ch;
      wr_pos = pos;
      tick();
      wr     = 1'b0;
   endtask

   task automatic doReset(input string tag);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput({tag, "_rst_servo"}, int'(servo), 0);
      checkOutput({tag, "_rst_busy"}, int'(busy), 0);
      checkOutput({tag, "_rst_tick"}, int'(frame_tick), 0);
   endtask

   // From IDLE, raise ena and land on the first cycle of the new frame.
   task automatic startRun(input string tag);
      ena = 1'b1;
      tick();
      checkOutput({tag, "_start_busy"}, int'(busy), 1);
   endtask

   // Observe one full frame starting at the current cycle. Optionally issue
   // a write during the last cycle so it lands on the reload edge.
   task automatic measureFrame(input bit wr_end, input logic [1:0] ch, input logic [N-1:0] pos);
      for (int k = 0; k < 4; k++) begin
         meas_width[k] = 0;
         meas_off[k]   = -1;
      end
      meas_ticks = 0;
      meas_first = -1;
      for (int c = 0; c < FRAME; c++) begin
         for (int k = 0; k < 4; k++) begin
            if (servo[k]) begin
               if (meas_off[k] < 0) meas_off[k] = c;
               meas_width[k]++;
            end
         end
         if (frame_tick) begin
            if (meas_first < 0) meas_first = c;
            meas_ticks++;
         end
         if (wr_end && c == FRAME - 1) begin
            wr     = 1'b1;
            wr_ch  = ch;
            wr_pos = pos;
         end
         tick();
         wr = 1'b0;
      end
   endtask

   task automatic checkFrame(input string tag, input logic [3:0][15:0] exp);
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("%s_width%0d", tag, k), meas_width[k], int'(exp[k]));
         checkOutput($sformatf("%s_offset%0d", tag, k), meas_off[k],
                     (exp[k] != 16'd0) ? T_SLOT * k : -1);
      end
      checkOutput({tag, "_ticks"}, meas_ticks, 1);
      checkOutput({tag, "_tick_pos"}, meas_first, 0);
   endtask

   task automatic waitIdle(input string tag, input int bound);
      int n;
      n = 0;
      while (busy && n < bound) begin
         tick();
         n++;
      end
      checkOutput({tag, "_idle"}, int'(busy), 0);
      checkOutput({tag, "_idle_servo"}, int'(servo), 0);
   endtask

   initial begin
      int hi;
      int last_hi;
      int idx;
      int others;
      int stray;

      assertions = 0;
      failures   = 0;
      rst    = 1'b1;
      ena    = 1'b0;
      wr     = 1'b0;
      wr_ch  = 2'd0;
      wr_pos = '0;

      vecs[0].pos   = {18'd0, 18'd80, 18'd5, 18'd20};
      vecs[0].width = {16'd0, 16'd50, 16'd10, 16'd20};
      vecs[1].pos   = {18'd50, 18'd10, 18'd9, 18'd1};
      vecs[1].width = {16'd50, 16'd10, 16'd10, 16'd10};
      vecs[2].pos   = {18'd65535, 18'd0, 18'd49, 18'd51};
      vecs[2].width = {16'd50, 16'd0, 16'd49, 16'd50};

      tick();
      tick();
      checkOutput("por_servo", int'(servo), 0);
      checkOutput("por_busy", int'(busy), 0);
      checkOutput("por_tick", int'(frame_tick), 0);
      rst = 1'b0;

      // Table: one frame per position set, then stop and drain.
      for (int i = 0; i < 3; i++) begin
         doReset($sformatf("vec%0d", i));
         for (int k = 0; k < 4; k++) begin
            applyStimulus(2'(k), vecs[i].pos[k]);
         end
         startRun($sformatf("vec%0d", i));
         measureFrame(1'b0, 2'd0, '0);
         checkFrame($sformatf("vec%0d", i), vecs[i].width);
         checkOutput($sformatf("vec%0d_period", i), int'(frame_tick), 1);
         ena = 1'b0;
         waitIdle($sformatf("vec%0d", i), 500);
      end

      // Write landing on the reload edge takes effect one frame late.
      doReset("reload");
      applyStimulus(2'd0, 18'd20);
      applyStimulus(2'd1, 18'd5);
      applyStimulus(2'd2, 18'd80);
      applyStimulus(2'd3, 18'd0);
      startRun("reload");
      measureFrame(1'b1, 2'd0, 18'd30);
      checkFrame("reload_f1", {16'd0, 16'd50, 16'd10, 16'd20});
      measureFrame(1'b0, 2'd0, '0);
      checkFrame("reload_f2", {16'd0, 16'd50, 16'd10, 16'd20});
      measureFrame(1'b0, 2'd0, '0);
      checkFrame("reload_f3", {16'd0, 16'd50, 16'd10, 16'd30});
      ena = 1'b0;
      waitIdle("reload", 500);

      // Three consecutive frames without writes repeat exactly.
      doReset("repeat");
      applyStimulus(2'd0, 18'd15);
      applyStimulus(2'd1, 18'd40);
      applyStimulus(2'd3, 18'd99);
      startRun("repeat");
      for (int f = 0; f < 3; f++) begin
         measureFrame(1'b0, 2'd0, '0);
         checkFrame($sformatf("repeat_f%0d", f), {16'd50, 16'd0, 16'd40, 16'd15});
      end
      ena = 1'b0;
      waitIdle("repeat", 500);

      // ena drop mid-pulse: pulse completes, busy falls one cycle later.
      doReset("drain");
      applyStimulus(2'd0, 18'd20);
      applyStimulus(2'd1, 18'd5);
      applyStimulus(2'd2, 18'd80);
      startRun("drain");
      for (int c = 0; c < 5; c++) tick();
      ena     = 1'b0;
      hi      = 0;
      last_hi = -1;
      others  = 0;
      idx     = 5;
      while (busy && idx < 500) begin
         tick();
         idx++;
         if (servo[0]) begin
            hi++;
            last_hi = idx;
         end
         if (servo[3:1] != 3'b000) others++;
      end
      checkOutput("drain_high_cycles", hi, 14);
      checkOutput("drain_last_high", last_hi, 19);
      checkOutput("drain_idle_at", idx, 21);
      checkOutput("drain_other_ch", others, 0);
      stray = 0;
      for (int c = 0; c < 500; c++) begin
         tick();
         if (servo != 4'b0000 || frame_tick || busy) stray++;
      end
      checkOutput("drain_quiet", stray, 0);

      // ena drop on the frame-end edge with channel 0 disabled.
      doReset("fend");
      applyStimulus(2'd1, 18'd20);
      startRun("fend");
      for (int c = 0; c < FRAME - 1; c++) tick();
      ena = 1'b0;
      tick();
      checkOutput("fend_no_tick", int'(frame_tick), 0);
      checkOutput("fend_busy", int'(busy), 1);
      checkOutput("fend_servo", int'(servo), 0);
      tick();
      checkOutput("fend_idle", int'(busy), 0);

      // Reset in the middle of channel 1's pulse.
      doReset("midrst");
      applyStimulus(2'd0, 18'd20);
      applyStimulus(2'd1, 18'd5);
      applyStimulus(2'd2, 18'd80);
      startRun("midrst");
      for (int c = 0; c < T_SLOT + 3; c++) tick();
      checkOutput("midrst_pre", int'(servo), 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("midrst_servo", int'(servo), 0);
      checkOutput("midrst_busy", int'(busy), 0);
      checkOutput("midrst_tick", int'(frame_tick), 0);
      tick();
      checkOutput("midrst_restart", int'(busy), 1);
      measureFrame(1'b0, 2'd0, '0);
      checkFrame("midrst_f", {16'd0, 16'd0, 16'd0, 16'd0});
      ena = 1'b0;
      waitIdle("midrst", 500);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
